// File: rtl/mmio_pkg.sv
// Shared MMIO page constants and the RX status word layout.
// RX_THRESH_OFF is only decoded when MMIO_RX_IRQ_EN is defined.
package mmio_pkg;

    localparam logic [19:0] MMIO_PAGE = 20'hAAAAA;

    // Existing write-side display/LED registers
    localparam logic [11:0] DISP_OFF      = 12'h004;
    localparam logic [11:0] DISP_CTRL_OFF = 12'h008;
    localparam logic [11:0] LED_OFF       = 12'h00C;

    localparam logic [11:0] RX_DATA_OFF   = 12'h010;
    localparam logic [11:0] RX_STATUS_OFF = 12'h014;
    localparam logic [11:0] RX_CTRL_OFF   = 12'h018;
    localparam logic [11:0] RX_THRESH_OFF = 12'h01C;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [4:0]  rsvd_lo;
        logic        overrun;
        logic        full;
        logic        empty;
    } rx_status_t;

endpackage

// File: rtl/mmio_rx_fifo.sv
// Byte FIFO with push, pop and flush; flush beats a same-cycle push.
// Storage is not reset, only pointers and count.
module mmio_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [7:0]       rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             dropped
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop at full frees the slot the push needs in the same cycle
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign dropped = push & ~flush & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_rx_reader.sv
// MMIO read-side UART RX peripheral: FIFO-backed data/status/ctrl registers
// with a 1-cycle registered read response. Optional IRQ/threshold: MMIO_RX_IRQ_EN.
module mmio_rx_reader
    import mmio_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [31:0] mem_addr,
    input  logic        mem_rd,
    input  logic        mem_wea,
    input  logic [31:0] mem_din,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        irq
);

    logic             page_hit, sel_data, sel_status, sel_ctrl, sel_thresh;
    logic             rd_fire, wr_fire, pop, flush, clr_ovr;
    logic [7:0]       head;
    logic [CNT_W-1:0] count;
    logic [15:0]      count_ext;
    logic             full, empty, dropped;
    logic             ovr_q;
    logic [31:0]      rd_value, rd_data_q;
    logic             rd_hit_q;
    rx_status_t       status;

    assign page_hit   = (mem_addr[31:12] == MMIO_PAGE);
    assign sel_data   = page_hit && (mem_addr[11:0] == RX_DATA_OFF);
    assign sel_status = page_hit && (mem_addr[11:0] == RX_STATUS_OFF);
    assign sel_ctrl   = page_hit && (mem_addr[11:0] == RX_CTRL_OFF);
`ifdef MMIO_RX_IRQ_EN
    assign sel_thresh = page_hit && (mem_addr[11:0] == RX_THRESH_OFF);
`else
    assign sel_thresh = 1'b0;
`endif

    // A simultaneous read suppresses the write
    assign rd_fire = mem_rd & (sel_data | sel_status | sel_thresh);
    assign wr_fire = mem_wea & ~mem_rd;
    assign pop     = mem_rd & sel_data;
    assign flush   = wr_fire & sel_ctrl & mem_din[0];
    assign clr_ovr = wr_fire & sel_ctrl & mem_din[1];

    mmio_rx_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_valid),
        .wdata   (rx_data),
        .pop     (pop),
        .flush   (flush),
        .rdata   (head),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .dropped (dropped)
    );

    assign count_ext = 16'(count);

    always_comb begin
        status         = '0;
        status.count   = count_ext[7:0];
        status.overrun = ovr_q;
        status.full    = full;
        status.empty   = empty;
    end

`ifdef MMIO_RX_IRQ_EN
    logic [7:0] thresh_q;
    logic       irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_q <= 8'd1;
            irq_q    <= 1'b0;
        end else begin
            if (wr_fire && sel_thresh) begin
                thresh_q <= (mem_din[7:0] == 8'd0) ? 8'd1 : mem_din[7:0];
            end
            irq_q <= (count_ext >= {8'd0, thresh_q}) | ovr_q;
        end
    end

    assign irq = irq_q;

    logic unused_din;
    assign unused_din = ^mem_din[31:8];
`else
    assign irq = 1'b0;

    logic unused_din;
    assign unused_din = ^mem_din[31:2];
`endif

    always_comb begin
        rd_value = 32'd0;
        if (sel_data) begin
            rd_value = empty ? 32'd0 : {23'd0, 1'b1, head};
        end else if (sel_status) begin
            rd_value = status;
`ifdef MMIO_RX_IRQ_EN
        end else if (sel_thresh) begin
            rd_value = {24'd0, thresh_q};
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q     <= 1'b0;
            rd_data_q <= 32'd0;
            rd_hit_q  <= 1'b0;
        end else begin
            ovr_q    <= (ovr_q & ~clr_ovr) | dropped;
            rd_hit_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_value;
            end
        end
    end

    assign rd_data = rd_data_q;
    assign rd_hit  = rd_hit_q;

endmodule

// File: doc/mmio_rx_reader.md
Name: mmio_rx_reader

Overview:
- MMIO read-side peripheral. Returns peripheral data to the core over the load path, in the reverse direction of the existing display/LED write decode.
- Buffers bytes from the UART receiver in a small FIFO. Exposes data, status and control registers in the 0xAAAAA_xxx MMIO page.
- Sits beside the memory controller. The controller muxes rd_data onto the core's load data whenever rd_hit is high.

Parameters:
- DEPTH, 16: FIFO entries. Must be a power of two, range 2..256.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width, derived.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rx_valid  in  1  one-cycle strobe from the UART receiver, byte valid
- rx_data  in  8  received byte, qualified by rx_valid
- mem_addr  in  32  core data address
- mem_rd  in  1  core load request, one cycle per access
- mem_wea  in  1  core store request
- mem_din  in  32  core store data
- rd_data  out  32  registered read data
- rd_hit  out  1  registered; high when rd_data belongs to this block
- irq  out  1  receive interrupt (see Optional Feature)

Behaviour:
- Decode: address hits when mem_addr[31:12] == 20'hAAAAA and mem_addr[11:0] is one of:
  - 0x010 RX_DATA, read-only
  - 0x014 RX_STATUS, read-only
  - 0x018 RX_CTRL, write-only
  - 0x01C RX_THRESH, read/write; exists only with the optional feature
- Other offsets in the page: reads and writes are ignored and rd_hit stays 0.
- Read latency is exactly 1 cycle:
  - A decoded mem_rd in cycle N gives rd_data/rd_hit in cycle N+1.
  - rd_hit is high for that one cycle only.
  - rd_data holds its last value until the next hit; it is 0 after reset.
- RX_DATA read:
  - FIFO non-empty: returns {23'b0, 1'b1, head byte} and pops one entry.
  - FIFO empty: returns 32'h0000_0000 and does not pop.
- RX_STATUS read returns {16'b0, count[7:0] (zero-extended from CNT_W), 5'b0, overrun, full, empty}. count is sampled in the request cycle.
- RX_CTRL write (mem_wea):
  - mem_din[0]=1 flushes the FIFO: count=0, pointers=0.
  - mem_din[1]=1 clears overrun.
  - Both may be set in the same write.
- FIFO push occurs on rx_valid:
  - Not full: the byte is written at the tail and count increments.
  - Full with no pop that cycle: the byte is dropped and overrun is set (sticky).
  - Full with a pop in the same cycle: push and pop both take effect, count is unchanged and overrun is not set.
  - Empty with a pop attempt in the same cycle: the pop returns empty-data (0) and the push completes, so count becomes 1. The FIFO has no bypass.
- Flush in the same cycle as a push: the flush wins, the byte is discarded, count=0.
- Pointers wrap modulo DEPTH. full = (count == DEPTH); empty = (count == 0).
- mem_rd and mem_wea together at the same address: the write is ignored and the read proceeds.
- Reset, asserted at any time, asynchronously clears:
  - pointers, count, overrun, rd_data, rd_hit, irq
  - threshold, which resets to 1
- FIFO storage contents are not reset.
- No state machine beyond the FIFO. Control is a pointer/counter datapath plus the registered read response stage.

Optional Feature:
- Macro: MMIO_RX_IRQ_EN
- Defined:
  - The RX_THRESH register exists, 8 bits in mem_din[7:0], reset value 1.
  - A threshold write of 0 is stored as 1.
  - irq is registered: irq = (count >= threshold) | overrun, evaluated every cycle, so it asserts 1 cycle after the condition.
  - A read of 0x01C returns {24'b0, threshold} with rd_hit=1.
- Undefined:
  - irq is tied 0.
  - The 0x01C offset is undecoded, so reads give rd_hit=0 and writes are ignored.

Decomposition:
- Package mmio_pkg holds:
  - MMIO_PAGE = 20'hAAAAA
  - offsets RX_DATA_OFF, RX_STATUS_OFF, RX_CTRL_OFF, RX_THRESH_OFF
  - the existing display/LED offsets 0x004, 0x008, 0x00C
  - a packed typedef rx_status_t for the status word layout
- One sub-module: mmio_rx_fifo, a parameterised synchronous FIFO with push, pop, flush, count, full and empty. Read decode and the response register stay in the top module.

Test Plan:
- Reset, then read 0xAAAAA014 -> next cycle rd_hit=1, rd_data=0x0000_0001 (empty); irq=0.
- Push 0x41, 0x42; read 0x010 twice -> rd_data=0x0000_0141 then 0x0000_0142; then status=0x0000_0001.
- Push DEPTH+1 bytes (16+1) -> status=0x0000_1006 (count 16, overrun, full); first read returns the first byte, and the 17th byte is absent.
- At full, push 0x55 in the same cycle as a pop -> no overrun, count stays 16, and 0x55 is read last.
- Write 0x3 to 0x018 while a push is pending -> status=0x0000_0001; a read of 0x020 gives rd_hit=0.
- With MMIO_RX_IRQ_EN, write 4 to 0x01C; push 3 bytes -> irq=0; push the 4th -> irq=1 one cycle later; assert rst mid-sequence -> irq and count are 0 immediately.
